serial_nibble_rx: RTL and testbench

SERIAL_NIBBLE_RX -- requirements
Module: serial_nibble_rx

---
 rtl/serial_nibble_rx_pkg.sv | 18 +
 rtl/rx_parity.sv | 11 +
 rtl/serial_nibble_rx.sv | 135 +++++++++++++
 tb/tb_serial_nibble_rx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_nibble_rx_pkg.sv
// Shared definitions for the serial nibble receiver: FSM state encoding and line constants.
package serial_nibble_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } rx_state_e;

    localparam logic IDLE_LEVEL = 1'b1;

    // Bit-counter width; a 1-bit word still needs a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/rx_parity.sv
// XOR-reduce of the received data word; high when the word has an odd number of ones.
module rx_parity #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] bits_i,
    output logic             odd_o
);

    assign odd_o = ^bits_i;

endmodule

// File: rtl/serial_nibble_rx.sv
// Framed serial-to-parallel receiver: start bit, WIDTH data bits LSB-first, optional even
// parity, stop bit. Frame outcome is registered one clock after the stop sample.
module serial_nibble_rx
    import serial_nibble_rx_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sin,
    output logic [WIDTH-1:0] data,
    output logic             load,
    output logic             perr,
    output logic             ferr,
    output logic             busy
);

    localparam int unsigned      CntW    = cnt_width(WIDTH);
    localparam logic [CntW-1:0]  LastBit = CntW'(WIDTH - 1);

    rx_state_e        state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             par_q, par_d;

    // Frame-end bookkeeping captured at the stop sample, resolved on the following edge.
    logic             done_q, done_d;
    logic             stop_q, stop_d;
    logic             par_bad_q, par_bad_d;

    logic [WIDTH-1:0] data_q, data_d;
    logic             load_q, load_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;

    logic             data_odd;

    rx_parity #(
        .WIDTH (WIDTH)
    ) u_rx_parity (
        .bits_i (shift_q),
        .odd_o  (data_odd)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        done_d    = 1'b0;
        stop_d    = stop_q;
        par_bad_d = par_bad_q;

        if (en) begin
            unique case (state_q)
                IDLE: begin
                    if (sin != IDLE_LEVEL) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    shift_d = (shift_q >> 1) | (WIDTH'(sin) << (WIDTH - 1));
                    cnt_d   = cnt_q + CntW'(1);
                    if (cnt_q == LastBit) begin
                        state_d = PARITY_EN ? PAR : STOP;
                    end
                end
                PAR: begin
                    par_d   = sin;
                    state_d = STOP;
                end
                STOP: begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    stop_d    = sin;
                    par_bad_d = PARITY_EN && (data_odd ^ par_q);
                end
            endcase
        end
    end

    // The shift register is stable in IDLE, so it still holds the frame word here.
    always_comb begin
        data_d = data_q;
        load_d = 1'b0;
        perr_d = 1'b0;
        ferr_d = 1'b0;
        if (done_q) begin
            ferr_d = (stop_q != IDLE_LEVEL);
            perr_d = par_bad_q;
            if (!ferr_d && !perr_d) begin
                load_d = 1'b1;
                data_d = shift_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            done_q    <= 1'b0;
            stop_q    <= 1'b0;
            par_bad_q <= 1'b0;
            data_q    <= '0;
            load_q    <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            done_q    <= done_d;
            stop_q    <= stop_d;
            par_bad_q <= par_bad_d;
            data_q    <= data_d;
            load_q    <= load_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign data = data_q;
    assign load = load_q;
    assign perr = perr_q;
    assign ferr = ferr_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_serial_nibble_rx.sv
// Self-checking bench for serial_nibble_rx: fixed vector table, directed frame sequences and
// randomized traffic compared against a frame-level reference model.
module tb_serial_nibble_rx;

    localparam int W = 4;

    logic       clk = 1'b0;
    logic       rst, en, sin;
    logic [3:0] data;
    logic       load, perr, ferr, busy;

    always #5 clk = ~clk;

    serial_nibble_rx #(
        .WIDTH     (4),
        .PARITY_EN (1'b1)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .sin  (sin),
        .data (data),
        .load (load),
        .perr (perr),
        .ferr (ferr),
        .busy (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: collects sampled bits of a frame and settles its outcome a clock later.
    logic [3:0] m_data;
    logic       m_load, m_perr, m_ferr;
    bit         m_inframe;
    bit         m_bits[$];
    bit         p_valid, p_perr, p_ferr;
    logic [3:0] p_word;

    int         en_cnt, load_cnt, perr_cnt, ferr_cnt;
    int         ld_en_q[$];
    logic [3:0] ld_data_q[$];
    logic       prev_load, prev_perr, prev_ferr;

    typedef struct {
        logic       r, e, s;
        logic       ld, pe, fe, bz;
        logic [3:0] d;
    } vec_t;
    vec_t tbl[13];

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic e, input logic s);
        int ones;
        if (r) begin
            m_data = 4'h0; m_load = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
            m_inframe = 1'b0; m_bits.delete(); p_valid = 1'b0;
            return;
        end
        m_load = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
        if (p_valid) begin
            m_perr = p_perr;
            m_ferr = p_ferr;
            if (!p_perr && !p_ferr) begin
                m_load = 1'b1;
                m_data = p_word;
            end
            p_valid = 1'b0;
        end
        if (e) begin
            if (!m_inframe) begin
                if (s == 1'b0) begin
                    m_inframe = 1'b1;
                    m_bits.delete();
                end
            end else begin
                m_bits.push_back(s);
                if (m_bits.size() == W + 2) begin
                    ones   = 0;
                    p_word = 4'h0;
                    for (int i = 0; i < W; i++) p_word = p_word + 4'(int'(m_bits[i]) * (1 << i));
                    for (int i = 0; i <= W; i++) ones += int'(m_bits[i]);
                    p_perr    = (ones % 2) != 0;
                    p_ferr    = (m_bits[W + 1] == 1'b0);
                    p_valid   = 1'b1;
                    m_inframe = 1'b0;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic e, input logic s);
        rst = r; en = e; sin = s;
        @(posedge clk);
        model_edge(r, e, s);
        #1;
        check1("data", data, m_data);
        check1("load", load, m_load);
        check1("perr", perr, m_perr);
        check1("ferr", ferr, m_ferr);
        check1("busy", busy, m_inframe);
        if (prev_load) check1("load_twice", load, 1'b0);
        if (prev_perr) check1("perr_twice", perr, 1'b0);
        if (prev_ferr) check1("ferr_twice", ferr, 1'b0);
        prev_load = load; prev_perr = perr; prev_ferr = ferr;
        if (e && !r) en_cnt++;
        if (load) begin
            load_cnt++;
            ld_en_q.push_back(en_cnt);
            ld_data_q.push_back(data);
        end
        if (perr) perr_cnt++;
        if (ferr) ferr_cnt++;
    endtask

    task automatic clear_counts();
        load_cnt = 0; perr_cnt = 0; ferr_cnt = 0; en_cnt = 0;
        ld_en_q.delete(); ld_data_q.delete();
    endtask

    // Sends start, data LSB-first, even parity (optionally inverted) and stop, with `gap`
    // idle-strobe cycles of random line noise before each bit.
    task automatic send_frame(input logic [3:0] w, input bit flip_par, input bit stop,
                              input int gap);
        bit fb[$];
        fb.push_back(1'b0);
        for (int i = 0; i < W; i++) fb.push_back(w[i]);
        fb.push_back((^w) ^ flip_par);
        fb.push_back(stop);
        foreach (fb[k]) begin
            repeat (gap) step(1'b0, 1'b0, 1'($urandom));
            step(1'b0, 1'b1, fb[k]);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sin = 1'b1;
        prev_load = 1'b0; prev_perr = 1'b0; prev_ferr = 1'b0;
        m_data = 4'h0; m_load = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
        m_inframe = 1'b0; p_valid = 1'b0; p_perr = 1'b0; p_ferr = 1'b0; p_word = 4'h0;
        clear_counts();

        //          r     e     s     ld    pe    fe    bz    d
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'hD};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hD};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0};

        #2;
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].r, tbl[i].e, tbl[i].s);
            check1($sformatf("tbl%0d_load", i), load, tbl[i].ld);
            check1($sformatf("tbl%0d_perr", i), perr, tbl[i].pe);
            check1($sformatf("tbl%0d_ferr", i), ferr, tbl[i].fe);
            check1($sformatf("tbl%0d_busy", i), busy, tbl[i].bz);
            check1($sformatf("tbl%0d_data", i), data, tbl[i].d);
        end

        // Parity error keeps the previous word.
        step(1'b1, 1'b1, 1'b1);
        send_frame(4'h6, 1'b0, 1'b1, 0);
        repeat (2) step(1'b0, 1'b1, 1'b1);
        check1("prev_word", data, 4'h6);
        clear_counts();
        send_frame(4'hD, 1'b1, 1'b1, 0);
        repeat (3) step(1'b0, 1'b1, 1'b1);
        check1("par_perr_cnt", perr_cnt, 1);
        check1("par_load_cnt", load_cnt, 0);
        check1("par_ferr_cnt", ferr_cnt, 0);
        check1("par_data", data, 4'h6);

        // Framing error.
        clear_counts();
        send_frame(4'h3, 1'b0, 1'b0, 0);
        repeat (3) step(1'b0, 1'b1, 1'b1);
        check1("frm_ferr_cnt", ferr_cnt, 1);
        check1("frm_perr_cnt", perr_cnt, 0);
        check1("frm_load_cnt", load_cnt, 0);
        check1("frm_data", data, 4'h6);

        // Sparse strobes with noise between them.
        clear_counts();
        send_frame(4'hA, 1'b0, 1'b1, 2);
        repeat (3) step(1'b0, 1'b1, 1'b1);
        check1("sparse_load_cnt", load_cnt, 1);
        check1("sparse_data", data, 4'hA);

        // Reset mid-frame, then a clean frame.
        clear_counts();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b1, 1'b1);
        check1("abort_no_pulse", load_cnt + perr_cnt + ferr_cnt, 0);
        send_frame(4'h5, 1'b0, 1'b1, 0);
        repeat (3) step(1'b0, 1'b1, 1'b1);
        check1("abort_load_cnt", load_cnt, 1);
        check1("abort_err_cnt", perr_cnt + ferr_cnt, 0);
        check1("abort_data", data, 4'h5);

        // Back-to-back frames with no idle bits.
        clear_counts();
        send_frame(4'h1, 1'b0, 1'b1, 0);
        send_frame(4'hF, 1'b0, 1'b1, 0);
        repeat (2) step(1'b0, 1'b1, 1'b1);
        check1("b2b_load_cnt", load_cnt, 2);
        if (ld_en_q.size() == 2) begin
            check1("b2b_spacing", ld_en_q[1] - ld_en_q[0], 7);
            check1("b2b_data0", ld_data_q[0], 4'h1);
            check1("b2b_data1", ld_data_q[1], 4'hF);
        end else begin
            check1("b2b_pulses_seen", ld_en_q.size(), 2);
        end

        // Random traffic against the model.
        step(1'b1, 1'b1, 1'b1);
        clear_counts();
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) < 6));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
